// File: rtl/pkt_rx_reader.sv
// pkt_rx_reader: reads frames out of the MAC receive packet FIFO, repairs
// SOP/EOP framing and re-emits always-terminated frames on a valid/ready
// stream through a small output FIFO, with per-frame length and statistics.
//
// Output handshake: a word transfers on a rising edge where out_val and
// out_ready are both 1. out_val never depends on out_ready, and while
// out_val=1 the word on out_* stays stable until it is accepted.
module pkt_rx_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_val,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic [2:0]  pkt_rx_mod,
  input  logic        pkt_rx_err,
  output logic [63:0] out_data,
  output logic        out_val,
  output logic        out_sop,
  output logic        out_eop,
  output logic [2:0]  out_mod,
  output logic        out_err,
  input  logic        out_ready,
  output logic        len_val,
  output logic [15:0] len_bytes,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Largest occupancy plus in-flight word count that still allows a new read.
  localparam logic [AW+1:0] REN_LIMIT = (AW+2)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic [63:0] data;
  } entry_t;

  state_t        state_q, state_d;
  logic          ren_q, ren_d1_q, ren_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ;
  logic [AW+1:0] occ_sum;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head;
  logic          full, fifo_we, fifo_re;

  // Per-word decisions from the output process
  logic          wr_en, drop, close, close_err;
  entry_t        wr_entry;
  logic [3:0]    add_bytes;
  logic [15:0]   len_base;
  logic [16:0]   len_sum;
  logic [15:0]   len_sat;

  logic [15:0]   len_acc_q;
  logic          len_val_q;
  logic [15:0]   len_bytes_q;
  logic [31:0]   frame_cnt_q;
  logic [15:0]   err_cnt_q;
  logic [15:0]   drop_cnt_q;

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign occ_sum = {1'b0, occ} + {{(AW+1){1'b0}}, ren_d1_q};
  assign full    = (occ == (AW+1)'(FIFO_DEPTH));
  assign fifo_we = wr_en && !full;
  assign fifo_re = out_val && out_ready;

  // Read request: keep reading while a frame is open or a packet is waiting,
  // as long as the words already requested still fit in the FIFO.
  assign ren_d = ((state_q != S_IDLE) || pkt_rx_avail) && (occ_sum <= REN_LIMIT);

  // FSM state register
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // FSM next state: framing decisions on each valid word
  always_comb begin
    state_d = state_q;
    if (pkt_rx_val) begin
      case (state_q)
        S_IDLE: begin
          if (pkt_rx_sop && !pkt_rx_eop)       state_d = S_FRAME;
          else if (!pkt_rx_sop && !pkt_rx_eop) state_d = S_DROP;
        end
        S_FRAME: begin
          if (pkt_rx_sop)      state_d = pkt_rx_eop ? S_IDLE : S_DROP;
          else if (pkt_rx_eop) state_d = S_IDLE;
        end
        S_DROP: begin
          if (pkt_rx_eop) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: what to write, drop or close for the current word
  always_comb begin
    wr_en     = 1'b0;
    drop      = 1'b0;
    close     = 1'b0;
    close_err = 1'b0;
    add_bytes = 4'd0;
    wr_entry  = '{sop: pkt_rx_sop, eop: pkt_rx_eop, mod: pkt_rx_mod,
                  err: pkt_rx_err, data: pkt_rx_data};
    if (pkt_rx_val) begin
      case (state_q)
        S_IDLE: begin
          if (pkt_rx_sop) begin
            wr_en     = 1'b1;
            close     = pkt_rx_eop;
            close_err = pkt_rx_err;
          end else begin
            drop = 1'b1;
          end
        end
        S_FRAME: begin
          wr_en = 1'b1;
          if (pkt_rx_sop) begin
            // A new SOP inside a frame: this word becomes a forced, errored
            // EOP so the open frame is still terminated downstream.
            wr_entry.sop = 1'b0;
            wr_entry.eop = 1'b1;
            wr_entry.mod = 3'd0;
            wr_entry.err = 1'b1;
            close        = 1'b1;
            close_err    = 1'b1;
          end else begin
            close     = pkt_rx_eop;
            close_err = pkt_rx_err;
          end
        end
        S_DROP:  drop = 1'b1;
        default: drop = 1'b0;
      endcase
    end
    if (wr_en) begin
      if (wr_entry.eop && wr_entry.mod != 3'd0) add_bytes = {1'b0, wr_entry.mod};
      else                                      add_bytes = 4'd8;
    end
  end

  // Saturating frame length; a SOP word in IDLE starts a fresh sum.
  assign len_base = (state_q == S_IDLE) ? 16'd0 : len_acc_q;
  assign len_sum  = {1'b0, len_base} + {13'd0, add_bytes};
  assign len_sat  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // Read-enable pipeline to the MAC
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      ren_q    <= 1'b0;
      ren_d1_q <= 1'b0;
    end else begin
      ren_q    <= ren_d;
      ren_d1_q <= ren_q;
    end
  end

  // Output FIFO pointers
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_we) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_re) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Output FIFO storage; contents are qualified by the pointers
  always_ff @(posedge clk_156m25) begin
    if (fifo_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // Frame length accumulator and statistics
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      len_acc_q   <= '0;
      len_val_q   <= 1'b0;
      len_bytes_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      len_val_q <= close;
      if (wr_en) len_acc_q <= len_sat;
      if (close) begin
        len_bytes_q <= len_sat;
        frame_cnt_q <= frame_cnt_q + 32'd1;
        if (close_err) err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign out_val    = (occ != '0);
  assign out_data   = out_val ? head.data : 64'd0;
  assign out_sop    = out_val && head.sop;
  assign out_eop    = out_val && head.eop;
  assign out_mod    = (out_val && head.eop) ? head.mod : 3'd0;
  assign out_err    = out_val && head.eop && head.err;

  assign pkt_rx_ren = ren_q;
  assign len_val    = len_val_q;
  assign len_bytes  = len_bytes_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Bench for pkt_rx_reader: a MAC packet-FIFO model feeds words on request,
// a word-level framing model builds the expected stream, lengths and counts.
module tb_pkt_rx_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avail = 1'b0;
  logic        ren;
  logic [63:0] rx_data = '0;
  logic        rx_val = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
  logic [2:0]  rx_mod = '0;
  logic [63:0] out_data;
  logic        out_val, out_sop, out_eop, out_err;
  logic [2:0]  out_mod;
  logic        ready = 1'b0;
  logic        len_val;
  logic [15:0] len_bytes, err_cnt, drop_cnt;
  logic [31:0] frame_cnt;
  logic [1:0]  dbg_state;

  pkt_rx_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .pkt_rx_avail(avail), .pkt_rx_ren(ren),
    .pkt_rx_data(rx_data), .pkt_rx_val(rx_val), .pkt_rx_sop(rx_sop),
    .pkt_rx_eop(rx_eop), .pkt_rx_mod(rx_mod), .pkt_rx_err(rx_err),
    .out_data(out_data), .out_val(out_val), .out_sop(out_sop),
    .out_eop(out_eop), .out_mod(out_mod), .out_err(out_err),
    .out_ready(ready), .len_val(len_val), .len_bytes(len_bytes),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 stalled
  logic prev_ren = 1'b0;

  // word format: {sop, eop, mod[2:0], err, data[63:0]}
  logic [69:0] mac_q[$];
  logic [69:0] exp_q[$];
  logic [15:0] len_q[$];

  // framing model state: 0 outside a frame, 1 inside, 2 discarding
  int          m_mode = 0;
  int          m_len = 0;
  logic [31:0] exp_frames = '0;
  logic [15:0] exp_errs = '0;
  logic [15:0] exp_drops = '0;

  function automatic logic [69:0] mk(input logic s, input logic e,
                                      input logic [2:0] m, input logic r);
    logic [63:0] d;
    d = {$urandom, $urandom};
    return {s, e, m, r, d};
  endfunction

  function automatic void model_close(input logic e);
    exp_frames = exp_frames + 32'd1;
    if (e) exp_errs = exp_errs + 16'd1;
    len_q.push_back((m_len > 65535) ? 16'hFFFF : 16'(m_len));
    m_len = 0;
  endfunction

  function automatic void model_word(input logic [69:0] w);
    logic s, e, r;
    logic [2:0] m;
    int bytes;
    s = w[69]; e = w[68]; m = w[67:65]; r = w[64];
    bytes = (e && m != 3'd0) ? int'(m) : 8;
    if (m_mode == 0) begin
      if (s) begin
        exp_q.push_back({1'b1, e, e ? m : 3'd0, e & r, w[63:0]});
        m_len = bytes;
        if (e) model_close(r);
        else   m_mode = 1;
      end else begin
        exp_drops = exp_drops + 16'd1;
        if (!e) m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (!s) begin
        exp_q.push_back({1'b0, e, e ? m : 3'd0, e & r, w[63:0]});
        m_len = m_len + bytes;
        if (e) begin
          model_close(r);
          m_mode = 0;
        end
      end else begin
        exp_q.push_back({1'b0, 1'b1, 3'd0, 1'b1, w[63:0]});
        m_len = m_len + 8;
        model_close(1'b1);
        m_mode = e ? 0 : 2;
      end
    end else begin
      exp_drops = exp_drops + 16'd1;
      if (e) m_mode = 0;
    end
  endfunction

  // ---------------- MAC packet FIFO model ----------------
  // Returns one buffered word in the cycle after each read enable.
  always @(negedge clk) begin
    logic [69:0] w;
    if (!rst_n) begin
      mac_q.delete(); exp_q.delete(); len_q.delete();
      prev_ren = 1'b0; avail = 1'b0;
      rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_mod = '0; rx_err = 1'b0;
      m_mode = 0; m_len = 0;
      exp_frames = '0; exp_errs = '0; exp_drops = '0;
    end else begin
      if (prev_ren && mac_q.size() > 0) begin
        w = mac_q.pop_front();
        {rx_sop, rx_eop, rx_mod, rx_err, rx_data} = w;
        rx_val = 1'b1;
        model_word(w);
      end else begin
        rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rx_mod = '0; rx_err = 1'b0; rx_data = {$urandom, $urandom};
      end
      prev_ren = ren;
      avail = (mac_q.size() != 0);
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [69:0] e;
    logic [15:0] l;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
    if (rst_n) begin
      if (out_val && ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_word: got %h with nothing required", {out_sop, out_eop, out_mod, out_err, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_sop, out_eop, out_mod, out_err, out_data} !== e) begin
            bad++;
            $display("FAIL out_word: got %h required %h", {out_sop, out_eop, out_mod, out_err, out_data}, e);
          end
        end
      end
      if (len_val) begin
        total++;
        if (len_q.size() == 0) begin
          bad++;
          $display("FAIL len_val: pulse with len %0d, none required", len_bytes);
        end else begin
          l = len_q.pop_front();
          if (len_bytes !== l) begin
            bad++;
            $display("FAIL len_bytes: got %0d required %0d", len_bytes, l);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (mac_q.size() == 0 && exp_q.size() == 0 && len_q.size() == 0 && !out_val)
        done = 1;
    end
    repeat (4) @(negedge clk);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: timeout, exp_q=%0d mac_q=%0d", exp_q.size(), mac_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({ren, out_val, out_sop, out_eop, out_mod, out_err, out_data, len_val, len_bytes,
         frame_cnt, err_cnt, drop_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_values: ren=%b val=%b len=%0d fc=%0d ec=%0d dc=%0d st=%0d",
               ren, out_val, len_bytes, frame_cnt, err_cnt, drop_cnt, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (ren !== 1'b0 || out_val !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: ren=%b out_val=%b required 0 0", ren, out_val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    ready_mode = 0;
    mac_q.push_back(mk(1, 0, 3'd0, 0));
    mac_q.push_back(mk(0, 0, 3'd0, 0));
    mac_q.push_back(mk(0, 1, 3'd5, 0));
    @(negedge clk); #1;
    total++;
    if (avail !== 1'b1 || ren !== 1'b0) begin
      bad++;
      $display("FAIL ren_before_avail: ren=%b required 0", ren);
    end
    @(negedge clk); #1;
    total++;
    if (ren !== 1'b1) begin
      bad++;
      $display("FAIL ren_after_avail: ren=%b required 1", ren);
    end
    @(negedge clk); #1;
    total++;
    if (out_val !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: out_val=%b required 0", out_val);
    end
    @(negedge clk); #1;
    total++;
    if (out_val !== 1'b1 || out_sop !== 1'b1) begin
      bad++;
      $display("FAIL latency_two: out_val=%b out_sop=%b required 1 1", out_val, out_sop);
    end
    wait_drain(200);
    total++;
    if (len_bytes !== 16'd21 || frame_cnt !== 32'd1) begin
      bad++;
      $display("FAIL single_stats: len=%0d fc=%0d required 21 1", len_bytes, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    for (int i = 0; i < 10; i++)
      mac_q.push_back(mk(i == 0, i == 9, 3'd0, 0));
    wait_drain(400);
    total++;
    if (len_bytes !== 16'd80 || frame_cnt !== 32'd2) begin
      bad++;
      $display("FAIL backpressure_stats: len=%0d fc=%0d required 80 2", len_bytes, frame_cnt);
    end
    ready_mode = 0;
  endtask

  task automatic test_stray();
    mac_q.push_back(mk(0, 0, 3'd0, 0));
    mac_q.push_back(mk(0, 1, 3'd3, 0));
    wait_drain(200);
    total++;
    if (drop_cnt !== 16'd2 || frame_cnt !== 32'd2 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL stray: dc=%0d fc=%0d st=%0d required 2 2 0", drop_cnt, frame_cnt, dbg_state);
    end
  endtask

  task automatic test_sop_inside();
    mac_q.push_back(mk(1, 0, 3'd0, 0));
    mac_q.push_back(mk(0, 0, 3'd0, 0));
    mac_q.push_back(mk(1, 0, 3'd2, 0));
    mac_q.push_back(mk(0, 0, 3'd0, 0));
    mac_q.push_back(mk(0, 1, 3'd4, 0));
    wait_drain(200);
    total++;
    if (len_bytes !== 16'd24 || err_cnt !== 16'd1 || drop_cnt !== 16'd4 || frame_cnt !== 32'd3) begin
      bad++;
      $display("FAIL sop_inside: len=%0d ec=%0d dc=%0d fc=%0d required 24 1 4 3",
               len_bytes, err_cnt, drop_cnt, frame_cnt);
    end
  endtask

  task automatic test_err_reset();
    for (int i = 0; i < 4; i++)
      mac_q.push_back(mk(i == 0, i == 3, 3'd0, i == 3));
    wait_drain(200);
    total++;
    if (len_bytes !== 16'd32 || err_cnt !== 16'd2 || frame_cnt !== 32'd4) begin
      bad++;
      $display("FAIL mac_err: len=%0d ec=%0d fc=%0d required 32 2 4", len_bytes, err_cnt, frame_cnt);
    end
    // open a frame and stall the output so it stays mid-frame
    ready_mode = 3;
    for (int i = 0; i < 8; i++)
      mac_q.push_back(mk(i == 0, i == 7, 3'd0, 0));
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (dbg_state !== 2'd1 || out_val !== 1'b1) begin
      bad++;
      $display("FAIL mid_frame: st=%0d out_val=%b required 1 1", dbg_state, out_val);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({ren, out_val, out_sop, out_eop, out_mod, out_err, out_data, len_val, len_bytes,
         frame_cnt, err_cnt, drop_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_mid_frame: ren=%b val=%b len=%0d fc=%0d ec=%0d dc=%0d st=%0d",
               ren, out_val, len_bytes, frame_cnt, err_cnt, drop_cnt, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    // the remainder of the abandoned frame arrives first and must be dropped
    mac_q.push_back(mk(0, 1, 3'd0, 0));
    mac_q.push_back(mk(1, 1, 3'd6, 0));
    wait_drain(200);
    total++;
    if (drop_cnt !== 16'd1 || frame_cnt !== 32'd1 || len_bytes !== 16'd6 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL after_reset: dc=%0d fc=%0d len=%0d ec=%0d required 1 1 6 0",
               drop_cnt, frame_cnt, len_bytes, err_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8193; i++)
      mac_q.push_back(mk(i == 0, i == 8192, 3'd0, 0));
    wait_drain(20000);
    total++;
    if (len_bytes !== 16'hFFFF) begin
      bad++;
      $display("FAIL len_saturate: got %h required ffff", len_bytes);
    end
  endtask

  task automatic test_random();
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        logic s, e;
        s = (i == 0);
        e = (i == n - 1);
        if ($urandom_range(0, 9) == 0) s = ~s;
        mac_q.push_back(mk(s, e, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0));
      end
    end
    wait_drain(5000);
    total++;
    if (frame_cnt !== exp_frames || err_cnt !== exp_errs || drop_cnt !== exp_drops) begin
      bad++;
      $display("FAIL random_counts: fc=%0d ec=%0d dc=%0d required %0d %0d %0d",
               frame_cnt, err_cnt, drop_cnt, exp_frames, exp_errs, exp_drops);
    end
    ready_mode = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stray();
    test_sop_inside();
    test_err_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
